// File: rtl/cache_lookup_ctrl.sv
// rtl/cache_lookup_ctrl.sv - trace-command front end: direct-mapped tag lookup,
// MESI op issue, tag store upkeep and hit/miss statistics.
module cache_lookup_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  input  logic [ADDR_W-1:0]  cmd_addr,
  output logic               cmd_ready,
  output logic               op_valid,
  output logic [1:0]         op,
  output logic               first_read,
  output logic [INDEX_W-1:0] op_index,
  output logic               hit,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam logic [INDEX_W:0] CLR_LAST = (INDEX_W + 1)'(SETS);

  localparam logic [2:0] C_READ   = 3'd0;
  localparam logic [2:0] C_WRITE  = 3'd1;
  localparam logic [2:0] C_IFETCH = 3'd2;
  localparam logic [2:0] C_SNP_INV = 3'd3;
  localparam logic [2:0] C_SNP_RD = 3'd4;
  localparam logic [2:0] C_CLEAR  = 3'd5;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_SNOOP = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_ISSUE,
    S_CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [INDEX_W-1:0] req_idx_q, req_idx_d;
  logic               lk_hit_q, lk_hit_d;
  logic [INDEX_W:0]   clr_cnt_q, clr_cnt_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]   tag_mem_q [SETS];
  logic [TAG_W-1:0]   tag_mem_d [SETS];

  logic               op_valid_q, op_valid_d;
  logic [1:0]         op_q, op_d;
  logic               first_read_q, first_read_d;
  logic [INDEX_W-1:0] op_index_q, op_index_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               tag_match;

  assign tag_match = valid_q[req_idx_q] && (tag_mem_q[req_idx_q] == req_tag_q);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    lk_hit_d     = lk_hit_q;
    clr_cnt_d    = clr_cnt_q;
    valid_d      = valid_q;
    tag_mem_d    = tag_mem_q;
    op_valid_d   = 1'b0;
    op_d         = op_q;
    first_read_d = first_read_q;
    op_index_d   = op_index_q;
    hit_d        = hit_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d     = cmd;
          req_tag_d = cmd_addr[ADDR_W-1:OFFSET_W+INDEX_W];
          req_idx_d = cmd_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
          if (cmd == C_CLEAR) begin
            clr_cnt_d = '0;
            state_d   = S_CLEAR;
          end else if (cmd > C_CLEAR) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end

      // Op outputs are registered here so they appear during ISSUE.
      S_LOOKUP: begin
        lk_hit_d = tag_match;
        state_d  = S_ISSUE;
        unique case (cmd_q)
          C_READ, C_IFETCH: begin
            op_valid_d   = 1'b1;
            op_d         = OP_READ;
            first_read_d = !tag_match;
            op_index_d   = req_idx_q;
            hit_d        = tag_match;
          end
          C_WRITE: begin
            op_valid_d   = 1'b1;
            op_d         = OP_WRITE;
            first_read_d = 1'b0;
            op_index_d   = req_idx_q;
            hit_d        = tag_match;
          end
          C_SNP_INV, C_SNP_RD: begin
            if (tag_match) begin
              op_valid_d   = 1'b1;
              op_d         = (cmd_q == C_SNP_INV) ? OP_INVAL : OP_SNOOP;
              first_read_d = 1'b0;
              op_index_d   = req_idx_q;
              hit_d        = 1'b1;
            end
          end
          default: ;
        endcase
      end

      S_ISSUE: begin
        state_d = S_IDLE;
        unique case (cmd_q)
          C_READ, C_IFETCH, C_WRITE: begin
            if (cmd_q == C_WRITE) wr_cnt_d = wr_cnt_q + CNT_W'(1);
            else                  rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (lk_hit_q) begin
              hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
              miss_cnt_d            = miss_cnt_q + CNT_W'(1);
              valid_d[req_idx_q]    = 1'b1;
              tag_mem_d[req_idx_q]  = req_tag_q;
            end
          end
          C_SNP_INV: begin
            if (lk_hit_q) valid_d[req_idx_q] = 1'b0;
          end
          default: ;
        endcase
      end

      // One set per cycle, plus a final cycle to hand back to IDLE.
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_IDLE;
        end else begin
          valid_d[clr_cnt_q[INDEX_W-1:0]] = 1'b0;
          clr_cnt_d = clr_cnt_q + (INDEX_W + 1)'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      lk_hit_q     <= 1'b0;
      clr_cnt_q    <= '0;
      valid_q      <= '0;
      op_valid_q   <= 1'b0;
      op_q         <= OP_WRITE;
      first_read_q <= 1'b0;
      op_index_q   <= '0;
      hit_q        <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      lk_hit_q     <= lk_hit_d;
      clr_cnt_q    <= clr_cnt_d;
      valid_q      <= valid_d;
      op_valid_q   <= op_valid_d;
      op_q         <= op_d;
      first_read_q <= first_read_d;
      op_index_q   <= op_index_d;
      hit_q        <= hit_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Tag payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign op_valid   = op_valid_q;
  assign op         = op_q;
  assign first_read = first_read_q;
  assign op_index   = op_index_q;
  assign hit        = hit_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// tb/tb_cache_lookup_ctrl.sv - scoreboard bench for cache_lookup_ctrl.
// Expected ops are queued by the driver and popped by an independent monitor.
module tb_cache_lookup_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [31:0] cmd_addr;
  logic        cmd_ready;
  logic        op_valid;
  logic [1:0]  op;
  logic        first_read;
  logic [3:0]  op_index;
  logic        hit;
  logic [15:0] rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  cache_lookup_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready), .op_valid(op_valid), .op(op), .first_read(first_read),
    .op_index(op_index), .hit(hit), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: {op, first_read, op_index, hit}
  always @(negedge clk) begin
    if (!reset && op_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_op: got op=%0d fr=%0d idx=%0d hit=%0d expected no op",
                 op, first_read, op_index, hit);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({op, first_read, op_index, hit} !== e) begin
          miscompares++;
          $display("FAIL op_fields: got op=%0d fr=%0d idx=%0d hit=%0d expected op=%0d fr=%0d idx=%0d hit=%0d",
                   op, first_read, op_index, hit, e[7:6], e[5], e[4:1], e[0]);
        end
      end
    end
  end

  // Issue one command; returns cycles cmd_ready stayed low and the cycle op_valid appeared.
  task automatic do_cmd(input logic [2:0] c, input logic [31:0] a, input bit pulse,
                        input logic [1:0] e_op, input logic e_fr, input logic [3:0] e_idx,
                        input logic e_hit, output int lowc, output int pulse_at);
    int n;
    lowc = -1;
    pulse_at = 0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    if (pulse) exp_q.push_back({e_op, e_fr, e_idx, e_hit});
    cmd_valid = 1'b1;
    cmd = c;
    cmd_addr = a;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (op_valid) pulse_at = k;
      if (cmd_ready) begin
        lowc = k - 1;
        break;
      end
    end
    if (lowc < 0) check("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic e_fr, input logic [3:0] e_idx);
    int l, p;
    do_cmd(3'd0, a, 1'b1, 2'b01, e_fr, e_idx, !e_fr, l, p);
  endtask

  int lowc, pat;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    cmd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", {op_valid, op, first_read, op_index, hit}, 32'd0);
    check("rst_counters", {rd_cnt | wr_cnt | hit_cnt | miss_cnt | err_cnt}, 32'd0);

    // Read miss then hit on set 1
    do_cmd(3'd0, 32'h0000_1040, 1'b1, 2'b01, 1'b1, 4'd1, 1'b0, lowc, pat);
    check("read_latency", 32'(pat), 32'd2);
    check("read_busy_cycles", 32'(lowc), 32'd2);
    check("rd_cnt_1", 32'(rd_cnt), 32'd1);
    check("miss_cnt_1", 32'(miss_cnt), 32'd1);
    rd(32'h0000_1040, 1'b0, 4'd1);
    check("hit_cnt_1", 32'(hit_cnt), 32'd1);

    // Write replaces tag in set 1
    do_cmd(3'd1, 32'h0000_2040, 1'b1, 2'b00, 1'b0, 4'd1, 1'b0, lowc, pat);
    check("wr_cnt_1", 32'(wr_cnt), 32'd1);
    rd(32'h0000_1040, 1'b1, 4'd1);

    // Snoops on set 2
    rd(32'h0000_0080, 1'b1, 4'd2);
    do_cmd(3'd3, 32'h0000_0080, 1'b1, 2'b11, 1'b0, 4'd2, 1'b1, lowc, pat);
    do_cmd(3'd4, 32'h0000_0080, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, lowc, pat);
    check("snoop_miss_no_pulse", 32'(pat), 32'd0);
    check("hold_after_no_pulse", {op, first_read, op_index, hit}, {2'b11, 1'b0, 4'd2, 1'b1});
    rd(32'h0000_0080, 1'b1, 4'd2);
    do_cmd(3'd4, 32'h0000_0080, 1'b1, 2'b10, 1'b0, 4'd2, 1'b1, lowc, pat);
    check("counts_after_snoops", {rd_cnt, hit_cnt}, {16'd5, 16'd1});
    check("miss_cnt_5", 32'(miss_cnt), 32'd5);

    // Fill all sets with tag 0: set 2 already holds tag 0, set 1 holds tag 4
    for (int i = 0; i < 16; i++) rd(32'(i) << 6, (i == 2) ? 1'b0 : 1'b1, 4'(i));
    check("fill_counts", {rd_cnt, hit_cnt}, {16'd21, 16'd2});
    check("fill_miss", 32'(miss_cnt), 32'd20);

    do_cmd(3'd5, 32'h0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, lowc, pat);
    check("clear_busy_cycles", 32'(lowc), 32'd17);
    rd(32'h0000_0000, 1'b1, 4'd0);
    rd(32'h0000_0080, 1'b1, 4'd2);
    rd(32'h0000_03C0, 1'b1, 4'd15);
    check("post_clear_miss", 32'(miss_cnt), 32'd23);

    // Reserved commands
    do_cmd(3'd6, 32'h0000_1040, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, lowc, pat);
    check("reserved_ready_stays", 32'(lowc), 32'd0);
    check("err_cnt_1", 32'(err_cnt), 32'd1);
    do_cmd(3'd7, 32'h0000_1040, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, lowc, pat);
    check("err_cnt_2", 32'(err_cnt), 32'd2);

    // Reset while a write to an installed line is in ISSUE
    rd(32'h0000_3000, 1'b1, 4'd0);
    rd(32'h0000_3000, 1'b0, 4'd0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 3'd1;
    cmd_addr = 32'h0000_3000;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("reset_kills_op_valid", 32'(op_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_counters", {rd_cnt | wr_cnt | hit_cnt | miss_cnt | err_cnt}, 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    rd(32'h0000_3000, 1'b1, 4'd0);
    check("after_reset_counts", {rd_cnt, miss_cnt}, {16'd1, 16'd1});

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_lookup_ctrl.md
# cache_lookup_ctrl

Trace-command front end for the per-line MESI state block. Accepts one trace command at a time, performs a direct-mapped tag lookup, and issues a registered 2-bit operation code (00 write, 01 read, 10 snoop, 11 invalidate) plus a `first_read` qualifier to the MESI stage. Also maintains the line-valid tag store and the hit/miss statistics counters.

## Interface
- `ADDR_W`, 32: trace address width.
- `OFFSET_W`, 6: byte-offset bits (64 B lines).
- `INDEX_W`, 4: set-index bits; SETS = 2^INDEX_W.
- `CNT_W`, 16: statistics counter width.
- `clk`  in  1  clock; reset reset, asynchronous, active-high; clock clk.
- `reset`  in  1  asynchronous active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd`  in  3  0 read, 1 write, 2 ifetch, 3 snoop-invalidate, 4 snoop-read, 5 clear-cache, 6/7 reserved.
- `cmd_addr`  in  ADDR_W  command address.
- `cmd_ready`  out  1  high only in IDLE.
- `op_valid`  out  1  one-cycle pulse; `op`/`first_read`/`op_index` valid.
- `op`  out  2  code for the MESI stage.
- `first_read`  out  1  1 on read/ifetch miss, else 0.
- `op_index`  out  INDEX_W  set index of the issued op.
- `hit`  out  1  lookup result, valid with `op_valid`.
- `rd_cnt`, `wr_cnt`, `hit_cnt`, `miss_cnt`, `err_cnt`  out  CNT_W  statistics.

## Operation
- Address split: tag = `cmd_addr[ADDR_W-1:OFFSET_W+INDEX_W]`, index = `cmd_addr[OFFSET_W+INDEX_W-1:OFFSET_W]`, offset ignored.
- Tag store: SETS entries of {valid, tag}; all valid bits 0 after reset.
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch cmd/addr. Cmd 5 goes to CLEAR, cmds 6/7 increment `err_cnt` and stay in IDLE, all others go to LOOKUP.
  - LOOKUP: read entry; hit = valid && tag match; go to ISSUE.
  - ISSUE: act per cmd below; return to IDLE.
  - CLEAR: clear valid of one set per cycle, index 0..SETS-1; return to IDLE after the last set.
- Per-command action in ISSUE:
  - 0/2: op=01, first_read=!hit; on miss install {1, tag}; `rd_cnt`++, plus `hit_cnt` or `miss_cnt`++.
  - 1: op=00, first_read=0; on miss install; `wr_cnt`++, plus `hit_cnt` or `miss_cnt`++.
  - 3: on hit op=11 pulse and valid cleared; on miss no pulse.
  - 4: on hit op=10 pulse, valid unchanged; on miss no pulse.
  - Snoops never touch hit/miss counters.
- Counters wrap modulo 2^CNT_W.
- `op`, `first_read`, `op_index`, `hit` hold their last values when `op_valid`=0.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `op_valid`=0, `op`=00, `first_read`=0, `op_index`=0, `hit`=0, all counters 0, all valid bits 0.
- Accept at edge E0. LOOKUP is active E0–E1. `op_valid` is high E1–E2, and the MESI stage samples it at E2. IDLE resumes after E2.
- Throughput: one command per 3 cycles. Clear-cache holds `cmd_ready` low for SETS+1 cycles.
- `cmd_valid` while `cmd_ready`=0 is ignored; the producer must hold it.
- Tag install/invalidate takes effect at E2, so the next command sees it.
- Reset mid-LOOKUP/ISSUE/CLEAR: command aborted, no `op_valid`, tag store fully invalidated.
- Reserved cmd: single cycle, `cmd_ready` stays 1, no pulse.

## Test plan
- Reset, then read 0x0000_1040 → `op_valid` 2 cycles after accept, op=01, first_read=1, hit=0, op_index=1, rd_cnt=1, miss_cnt=1. Repeat the read → first_read=0, hit=1, hit_cnt=1.
- Write 0x0000_2040 (same index, new tag) → op=00, hit=0, wr_cnt=1. Then read 0x0000_1040 → miss, first_read=1 (tag was replaced).
- Read 0x80, then snoop-invalidate 0x80 → op=11 pulse. Then snoop-read 0x80 → no pulse. Then read 0x80 → first_read=1.
- Fill sets 0–15, issue clear-cache → `cmd_ready` low 17 cycles. Each following read → first_read=1.
- cmd=6 → `err_cnt`=1, no `op_valid`, `cmd_ready` never drops.
- Assert reset during ISSUE of a write → no `op_valid`, counters 0. A following read to the same address → miss.
